// File: rtl/vid_frame_monitor.sv
// vid_frame_monitor: per-frame signature monitor for an RGB video stream with
// active-low HSYNC_n/VSYNC_n. Counts active lines and line lengths and computes
// a CRC-32 over the active pixels. A programmable number of warm-up frames is
// skipped, then a programmable number of frames is reported, one pulse each.
module vid_frame_monitor #(
  parameter int COLOR_W     = 3,
  parameter int PIX_CNT_W   = 11,
  parameter int LINE_CNT_W  = 10,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset_N,
  input  logic                   pix_en,
  input  logic [COLOR_W-1:0]     VIDEO_R,
  input  logic [COLOR_W-1:0]     VIDEO_G,
  input  logic [COLOR_W-1:0]     VIDEO_B,
  input  logic                   HSYNC_n,
  input  logic                   VSYNC_n,
  input  logic                   start,
  input  logic [FRAME_CNT_W-1:0] skip_frames,
  input  logic [FRAME_CNT_W-1:0] num_frames,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_idx,
  output logic [31:0]            frame_crc,
  output logic [LINE_CNT_W-1:0]  frame_lines,
  output logic [PIX_CNT_W-1:0]   line_len_min,
  output logic [PIX_CNT_W-1:0]   line_len_max,
  output logic                   len_err,
  output logic                   busy,
  output logic                   capture_done
);

  localparam int          PIX_W    = 3 * COLOR_W;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SKIP,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // Advance the CRC by one pixel word, most significant bit first.
  function automatic logic [31:0] crc_step(input logic [31:0] crc_in,
                                           input logic [PIX_W-1:0] word);
    logic [31:0] c;
    c = crc_in;
    for (int i = PIX_W - 1; i >= 0; i--) begin
      if (c[31] ^ word[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  state_t                 state;
  logic                   hs_q, vs_q;
  logic                   hs_fall, vs_fall, pix_active, close_line, first_line;
  logic [PIX_W-1:0]       pix_word;
  logic [PIX_CNT_W-1:0]   line_cnt, min_acc, max_acc, min_next, max_next;
  logic [LINE_CNT_W-1:0]  lines_acc, lines_next;
  logic [31:0]            crc_acc;
  logic [FRAME_CNT_W-1:0] skip_cnt, num_cnt, cap_idx;

  assign hs_fall    = hs_q & ~HSYNC_n;
  assign vs_fall    = vs_q & ~VSYNC_n;
  assign pix_active = pix_en & HSYNC_n & VSYNC_n;
  assign pix_word   = {VIDEO_R, VIDEO_G, VIDEO_B};
  // A line is closed at most once per cycle, whether HSYNC, VSYNC or both fall.
  assign close_line = (hs_fall | vs_fall) & (line_cnt != '0);
  assign first_line = (lines_acc == '0);

  // Frame statistics as they stand once the pending line is closed this cycle.
  always_comb begin
    lines_next = lines_acc;
    min_next   = min_acc;
    max_next   = max_acc;
    if (close_line) begin
      if (!(&lines_acc)) lines_next = lines_acc + LINE_CNT_W'(1);
      if (first_line || line_cnt < min_acc) min_next = line_cnt;
      if (first_line || line_cnt > max_acc) max_next = line_cnt;
    end
  end

  // Sync history for falling-edge detection, sampled every clock.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      hs_q <= HSYNC_n;
      vs_q <= VSYNC_n;
    end
  end

  // Per-frame accumulators: pixel count, line stats and CRC, cleared at every frame boundary.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      line_cnt  <= '0;
      lines_acc <= '0;
      min_acc   <= '0;
      max_acc   <= '0;
      crc_acc   <= CRC_INIT;
    end else if (start || vs_fall) begin
      line_cnt  <= '0;
      lines_acc <= '0;
      min_acc   <= '0;
      max_acc   <= '0;
      crc_acc   <= CRC_INIT;
    end else begin
      if (close_line) begin
        line_cnt  <= '0;
        lines_acc <= lines_next;
        min_acc   <= min_next;
        max_acc   <= max_next;
      end else if (pix_active && !(&line_cnt)) begin
        line_cnt <= line_cnt + PIX_CNT_W'(1);
      end
      if (pix_active) crc_acc <= crc_step(crc_acc, pix_word);
    end
  end

  // Capture sequencer: arm, align to a frame edge, skip warm-up frames, report captured frames.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state        <= ST_IDLE;
      skip_cnt     <= '0;
      num_cnt      <= '0;
      cap_idx      <= '0;
      frame_done   <= 1'b0;
      frame_idx    <= '0;
      frame_crc    <= '0;
      frame_lines  <= '0;
      line_len_min <= '0;
      line_len_max <= '0;
      len_err      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (start) begin
        skip_cnt  <= skip_frames;
        num_cnt   <= (num_frames == '0) ? FRAME_CNT_W'(1) : num_frames;
        cap_idx   <= '0;
        frame_idx <= '0;
        state     <= ST_SYNC;
      end else if (vs_fall) begin
        case (state)
          ST_SYNC: state <= (skip_cnt != '0) ? ST_SKIP : ST_CAPTURE;
          ST_SKIP: begin
            skip_cnt <= skip_cnt - FRAME_CNT_W'(1);
            if (skip_cnt == FRAME_CNT_W'(1)) state <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            frame_done   <= 1'b1;
            frame_idx    <= cap_idx;
            frame_crc    <= crc_acc;
            frame_lines  <= lines_next;
            line_len_min <= min_next;
            line_len_max <= max_next;
            len_err      <= (min_next != max_next);
            cap_idx      <= cap_idx + FRAME_CNT_W'(1);
            if (cap_idx == num_cnt - FRAME_CNT_W'(1)) state <= ST_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy         = (state == ST_SYNC) || (state == ST_SKIP) || (state == ST_CAPTURE);
  assign capture_done = (state == ST_DONE);

endmodule
